// File: rtl/l2_norm_stream_ctrl.sv
// Stream controller for the L2-norm datapath: buffers producer bytes, feeds one
// vector per start, collects the final root and offers it on a valid/ready port.
module l2_norm_stream_ctrl #(
   parameter int VEC_LEN = 8,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       start,
   output logic       busy,
   output logic [7:0] a,
   output logic       valid_in,
   output logic       norm_reset,
   input  logic [9:0] g,
   input  logic       valid_out,
   output logic [9:0] res_data,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_err
);

   localparam int DATA_W = 8;
   localparam int RES_W  = 10;
   localparam int AW     = $clog2(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [7:0]  VEC_N    = 8'(VEC_LEN);
   localparam logic [7:0]  LAST_IDX = 8'(VEC_LEN - 1);
   localparam logic [7:0]  TO_N     = 8'(TIMEOUT);
   localparam logic [AW:0] FULL_N   = (AW + 1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [2:0]        state;
   logic [7:0]        sent;
   logic [7:0]        recv;
   logic [7:0]        idle_cnt;
   logic [7:0]        recv_nxt;
   logic [7:0]        idle_nxt;
   logic              push;
   logic              pop;
   logic              empty;

   assign empty      = (count == '0);
   assign in_ready   = (count != FULL_N);
   assign push       = in_valid && in_ready;
   assign pop        = (state == S_SEND) && (sent < VEC_N) && !empty;
   assign busy       = (state != S_IDLE);
   assign norm_reset = reset || (state == S_CLEAR);
   assign recv_nxt   = recv + 8'd1;
   assign idle_nxt   = idle_cnt + 8'd1;

   // Input FIFO: storage is data only, pointers and occupancy are control.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Output stage to the datapath: popped byte appears one cycle after the pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         a        <= '0;
         valid_in <= 1'b0;
      end else begin
         valid_in <= pop;
         if (pop) a <= mem[rd_ptr];
      end
   end

   // Sequencer: clear datapath, send VEC_LEN bytes, collect results, hand off.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         sent      <= '0;
         recv      <= '0;
         idle_cnt  <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_CLEAR;
            end
            S_CLEAR: begin
               sent     <= '0;
               recv     <= '0;
               idle_cnt <= '0;
               state    <= S_SEND;
            end
            S_SEND: begin
               if (valid_out) recv <= recv_nxt;
               if (pop) begin
                  sent <= sent + 8'd1;
                  if (sent == LAST_IDX) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (valid_out) begin
                  recv     <= recv_nxt;
                  idle_cnt <= '0;
                  if (recv_nxt == VEC_N) begin
                     res_data  <= g;
                     res_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end else if (idle_nxt == TO_N) begin
                  // Datapath went quiet: report whatever root it currently shows.
                  idle_cnt  <= idle_nxt;
                  res_data  <= g;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  idle_cnt <= idle_nxt;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_err   <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic unused_w;
   assign unused_w = (RES_W == 10);

endmodule

// File: doc/l2_norm_stream_ctrl.md
Name: l2_norm_stream_ctrl

Overview:
- Transmitter/controller for the streaming L2-norm datapath.
- Buffers incoming bytes in a FIFO and, on start, clears the norm datapath.
- Streams exactly VEC_LEN bytes on the datapath's a/valid_in port, counts the returning valid_out pulses and captures g on the last one.
- Presents the captured result on a valid/ready result port.
- Sits between the vector producer and the norm datapath; one norm computation per start.

Parameters:
VEC_LEN, 8, bytes per vector (2..255)
DEPTH, 16, input FIFO depth in bytes (power of 2, >= VEC_LEN)
TIMEOUT, 15, max cycles in WAIT with no valid_out before error (1..255)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
in_data  input  8  producer byte
in_valid  input  1  producer byte valid
in_ready  output  1  FIFO can accept (= !full)
start  input  1  begin one vector; sampled only in IDLE
busy  output  1  high in any state but IDLE
a  output  8  byte to norm datapath
valid_in  output  1  byte valid to norm datapath
norm_reset  output  1  reset to norm datapath
g  input  10  norm datapath root
valid_out  input  1  norm datapath result valid (one pulse per byte, 3 cycles after valid_in)
res_data  output  10  captured norm
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_err  output  1  sticky timeout flag, qualified by res_valid

Behaviour:
- One clock: clk. Synchronous active-high reset. On reset: FIFO empty, state IDLE, counters 0, a=0, valid_in=0, res_data=0, res_valid=0, res_err=0, busy=0.
- norm_reset = reset OR (state==CLEAR), combinational.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in SEND while the sent count < VEC_LEN and the FIFO is non-empty.
  - No bypass: a byte pushed at cycle t is poppable at t+1 earliest.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - When full, in_ready=0, so no push; no data is lost or overwritten.
  - Pointers wrap modulo DEPTH.
- a/valid_in are registered: a pop at cycle t drives valid_in=1 and a=popped byte at t+1. valid_in=0 otherwise, and a holds its last value.
- FSM:
  - IDLE: if start, go to CLEAR. start while busy is ignored.
  - CLEAR (1 cycle): norm_reset=1, sent/recv counters cleared. Next state SEND.
  - SEND: pop one byte per cycle whenever the FIFO is non-empty. Empty-FIFO gaps are allowed, and valid_in stays low during them. After the VEC_LEN-th pop, go to WAIT.
  - WAIT:
    - recv increments on each valid_out.
    - When recv reaches VEC_LEN, latch res_data=g from that same cycle, set res_valid=1, and go to DONE.
    - An idle counter resets on each valid_out and increments otherwise. If it reaches TIMEOUT, set res_err=1, res_data=g, res_valid=1, and go to DONE.
    - valid_out pulses arriving during SEND are also counted.
  - DONE: hold res_data/res_valid/res_err stable until res_ready. On the res_valid && res_ready cycle, clear res_valid/res_err and go to IDLE.
- valid_out outside SEND/WAIT is ignored.
- FIFO bytes beyond VEC_LEN stay buffered for the next start.
- Latency with a pre-filled FIFO:
  - start at cycle 0, CLEAR at 1, first valid_in at 3.
  - Last valid_in at 2+VEC_LEN; last valid_out at 5+VEC_LEN.
  - res_valid at 6+VEC_LEN (=14 for defaults).
- Reset mid-operation (any state) returns everything to reset values in the next cycle and discards FIFO contents and any pending result.
- Widths: sent/recv counters are 8 bits, FIFO count is log2(DEPTH)+1 bits, no overflow possible within ranges.

Test Plan:
- FIFO pre-loaded with 8x 0x03, start -> 8 valid_in pulses on consecutive cycles; res_data=8 (sqrt 72), res_err=0, res_valid at cycle 14 after start.
- Vector {3,4,0,0,0,0,0,0}, then a second vector 8x 0xFF with a second start -> first res_data=5, second res_data=721 (floor sqrt 520200). The second result must not include the first vector's sum, which proves norm_reset pulses once per start.
- Producer feeds 1 byte every 3rd cycle after start -> valid_in has gaps, exactly 8 bytes sent, correct result; in_ready never deasserts.
- Push 17 bytes with start low -> in_ready=0 after 16, 17th byte held by producer; with push and pop in one cycle while full-1, occupancy is unchanged.
- Stub the norm datapath to drop valid_out after 5 pulses -> after 15 idle cycles res_valid=1, res_err=1; hold res_ready=0 for 4 cycles: outputs stable; then res_ready=1 -> IDLE, busy=0.
- Assert reset in SEND after 3 pops -> next cycle: valid_in=0, busy=0, in_ready=1, FIFO empty, norm_reset=1 during reset; a subsequent full vector computes correctly.
